// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter: FSM encoding, grant width, default timing.
// Pure declarations; no latency or backpressure of its own.
package uart_pkg;

    localparam int GRANT_W     = 3;
    localparam int TO_W_DEF    = 16;
    localparam int GAP_CYC_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Round-robin pointer advance: the slot after the winner, wrapping at nreq-1.
    function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] idx, input int nreq);
        return (int'(idx) == nreq - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake plus UART send/busy/data and error signalling, bundled as one port.
// Wiring only; timing and backpressure come from the arbiter driving the slave side.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*8-1:0]  req_data;
    logic [NREQ-1:0]    ack;
    logic [GRANT_W-1:0] grant_id;
    logic               uart_send;
    logic [7:0]         uart_data;
    logic               uart_busy;
    logic               err_clear;
    logic               err_timeout;
    logic               ctrl_busy;

    modport master (
        output req, req_data, uart_busy, err_clear,
        input  ack, grant_id, uart_send, uart_data, err_timeout, ctrl_busy
    );

    modport slave (
        input  req, req_data, uart_busy, err_clear,
        output ack, grant_id, uart_send, uart_data, err_timeout, ctrl_busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping NREQ-1 -> 0.
// Zero latency; no backpressure, the caller decides when the pick is consumed.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]    req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NREQ-1:0]    win_oh,
    output logic               win_vld,
    output logic [GRANT_W-1:0] win_idx
);

    always_comb begin
        win_oh  = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!win_vld && req[i] && ((int'(ptr) + k) % NREQ) == i) begin
                    win_vld   = 1'b1;
                    win_idx   = GRANT_W'(i);
                    win_oh[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NREQ byte producers; one byte captured per grant.
// Latency: req -> ack 2 cycles, -> uart_send 3 cycles; requesters wait while a frame is in flight or busy_s=1.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TO_W    = TO_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic             clk_CPU,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             state_q, state_d;
    logic               busy_m, busy_s;
    logic [GRANT_W-1:0] rr_ptr, win_q, grant_q, arb_idx;
    logic [NREQ-1:0]    arb_oh, win_oh_q, ack_q, ack_d;
    logic               arb_vld;
    logic [7:0]         data_q, data_sel;
    logic               send_q, send_d, err_q;
    logic [TO_W-1:0]    to_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               to_done, gap_done, to_set;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req     (bus.req),
        .ptr     (rr_ptr),
        .win_oh  (arb_oh),
        .win_vld (arb_vld),
        .win_idx (arb_idx)
    );

    always_ff @(posedge clk_CPU or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        to_set   = 1'b0;
        to_done  = (to_cnt == {TO_W{1'b1}});
        gap_done = (gap_cnt == GAP_W'(GAP_CYC - 1));
        case (state_q)
            ST_IDLE:  if (!busy_s && arb_vld) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SEND;
            ST_SEND: begin
                if (busy_s) begin
                    state_d = ST_DRAIN;
                end else if (to_done) begin
                    state_d = ST_DRAIN;
                    to_set  = 1'b1;
                end
            end
            ST_DRAIN: if (!busy_s) state_d = ST_GAP;
            ST_GAP:   if (gap_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Registered send drops on the same edge the FSM leaves SEND, so it is never high outside it.
        send_d   = (state_q == ST_SEND) && (state_d == ST_SEND);
        ack_d    = (state_q == ST_LOAD) ? win_oh_q : '0;
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q == GRANT_W'(i)) data_sel = bus.req_data[8*i +: 8];
        end
    end

    // Synchroniser resets to "busy" so a frame still leaving the UART at reset release blocks grants.
    always_ff @(posedge clk_CPU or posedge reset) begin
        if (reset) begin
            busy_m   <= 1'b1;
            busy_s   <= 1'b1;
            rr_ptr   <= '0;
            win_q    <= '0;
            win_oh_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            send_q   <= 1'b0;
            err_q    <= 1'b0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            busy_m <= bus.uart_busy;
            busy_s <= busy_m;
            ack_q  <= ack_d;
            send_q <= send_d;
            if (to_set)             err_q <= 1'b1;
            else if (bus.err_clear) err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_LOAD) begin
                        win_q    <= arb_idx;
                        win_oh_q <= arb_oh;
                    end
                end
                ST_LOAD: begin
                    data_q  <= data_sel;
                    grant_q <= win_q;
                    rr_ptr  <= next_ptr(win_q, NREQ);
                    to_cnt  <= '0;
                end
                ST_SEND:  to_cnt  <= to_cnt + 1'b1;
                ST_DRAIN: gap_cnt <= '0;
                ST_GAP:   gap_cnt <= gap_cnt + 1'b1;
                default:  ;
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant_id    = grant_q;
    assign bus.uart_send   = send_q;
    assign bus.uart_data   = data_q;
    assign bus.err_timeout = err_q;
    assign bus.ctrl_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=2, TO_W=4, GAP_CYC=3) with a simple UART busy model.
module tb_uart_tx_arbiter;

    logic clk_CPU = 1'b0;
    logic reset   = 1'b1;
    logic model_en = 1'b1;
    logic tb_busy  = 1'b0;
    int   mdl_cnt  = 0;

    int n_vec = 0;
    int n_err = 0;

    int          ack_cnt0 = 0, ack_cnt1 = 0, send_rises = 0, overlap = 0;
    logic        prev_send = 1'b0;
    int          log_id[$];
    logic [7:0]  log_data[$];

    uart_tx_arbiter_if #(.NREQ(2)) bus ();

    uart_tx_arbiter #(.NREQ(2), .TO_W(4), .GAP_CYC(3)) dut (
        .clk_CPU (clk_CPU),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_CPU = ~clk_CPU;

    // UART model: sees send, goes busy for 20 cycles.
    always @(posedge clk_CPU) begin
        if (mdl_cnt != 0)                     mdl_cnt <= mdl_cnt - 1;
        else if (model_en && bus.uart_send)   mdl_cnt <= 20;
    end

    always_comb bus.uart_busy = model_en ? (mdl_cnt != 0) : tb_busy;

    always @(negedge clk_CPU) begin
        if (bus.ack[0]) ack_cnt0++;
        if (bus.ack[1]) ack_cnt1++;
        if (bus.ack != 2'b00) begin
            log_id.push_back(int'(bus.grant_id));
            log_data.push_back(bus.uart_data);
        end
        if (bus.uart_send && !prev_send) begin
            send_rises++;
            if (bus.uart_busy) overlap++;
        end
        prev_send = bus.uart_send;
    end

    task automatic tick();
        @(posedge clk_CPU);
        #1;
    endtask

    task automatic wait_ack(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (bus.ack != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_send(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (bus.uart_send) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!bus.ctrl_busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        bus.req = 2'b00; bus.req_data = 16'h0000; bus.err_clear = 1'b0;
        reset = 1'b1;
        tick(); tick();
        n_vec++; if (bus.uart_send !== 1'b0)   begin n_err++; $display("FAIL reset_send: got %b want 0", bus.uart_send); end
        n_vec++; if (bus.uart_data !== 8'h00)  begin n_err++; $display("FAIL reset_data: got %h want 00", bus.uart_data); end
        n_vec++; if (bus.ack !== 2'b00)        begin n_err++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
        n_vec++; if (bus.grant_id !== 3'd0)    begin n_err++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
        n_vec++; if (bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err_timeout); end
        n_vec++; if (bus.ctrl_busy !== 1'b0)   begin n_err++; $display("FAIL reset_ctrl_busy: got %b want 0", bus.ctrl_busy); end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_single();
        int a0, s0;
        bit ok;
        a0 = ack_cnt0; s0 = send_rises;
        bus.req = 2'b01; bus.req_data = 16'h0055;
        tick();
        n_vec++; if (bus.ack !== 2'b00 || bus.ctrl_busy !== 1'b1) begin n_err++; $display("FAIL single_load: ack %b busy %b want 00/1", bus.ack, bus.ctrl_busy); end
        tick();
        n_vec++; if (bus.ack !== 2'b01)       begin n_err++; $display("FAIL single_ack: got %b want 01", bus.ack); end
        n_vec++; if (bus.uart_data !== 8'h55) begin n_err++; $display("FAIL single_data: got %h want 55", bus.uart_data); end
        n_vec++; if (bus.uart_send !== 1'b0)  begin n_err++; $display("FAIL single_send_early: got %b want 0", bus.uart_send); end
        bus.req = 2'b00;
        tick();
        n_vec++; if (bus.uart_send !== 1'b1 || bus.ack !== 2'b00) begin n_err++; $display("FAIL single_send_rise: send %b ack %b want 1/00", bus.uart_send, bus.ack); end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.uart_send) begin ok = 1'b1; break; end
        end
        n_vec++; if (!ok || bus.uart_busy !== 1'b1) begin n_err++; $display("FAIL single_send_release: released %b busy %b want 1/1", ok, bus.uart_busy); end
        wait_idle(80, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_idle: ctrl_busy stuck, want 0"); end
        n_vec++; if (send_rises - s0 != 1) begin n_err++; $display("FAIL single_frames: got %0d want 1", send_rises - s0); end
        n_vec++; if (ack_cnt0 - a0 != 1)   begin n_err++; $display("FAIL single_ack_count: got %0d want 1", ack_cnt0 - a0); end
    endtask

    task automatic test_busy_at_reset();
        int a1;
        bit ok, got;
        model_en = 1'b0; tb_busy = 1'b1;
        reset = 1'b1;
        bus.req = 2'b10; bus.req_data = 16'h9D00;
        tick(); tick();
        reset = 1'b0;
        a1 = ack_cnt1;
        got = 1'b0;
        repeat (10) begin
            tick();
            if (bus.ack != 2'b00) got = 1'b1;
        end
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL busyrst_blocked: ack seen %b want 0", got); end
        model_en = 1'b1;
        wait_ack(20, ok);
        n_vec++; if (!ok || bus.ack !== 2'b10) begin n_err++; $display("FAIL busyrst_ack: got %b want 10", bus.ack); end
        n_vec++; if (bus.uart_data !== 8'h9D)  begin n_err++; $display("FAIL busyrst_data: got %h want 9d", bus.uart_data); end
        bus.req = 2'b00;
        wait_idle(80, ok);
        n_vec++; if (!ok || ack_cnt1 - a1 != 1) begin n_err++; $display("FAIL busyrst_count: got %0d want 1", ack_cnt1 - a1); end
    endtask

    task automatic test_contention();
        int         base, s0, ov0, nacks;
        int         exp_id [4]   = '{0, 1, 0, 1};
        logic [7:0] exp_dat [4]  = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
        bit         ok;
        base = log_id.size(); s0 = send_rises; ov0 = overlap; nacks = 0;
        bus.req = 2'b11; bus.req_data = 16'hB2A1;
        for (int i = 0; i < 400 && nacks < 4; i++) begin
            tick();
            if (bus.ack != 2'b00) begin
                nacks++;
                if (nacks == 4) bus.req = 2'b00;
            end
        end
        bus.req = 2'b00;
        wait_idle(80, ok);
        n_vec++; if (log_id.size() - base != 4) begin n_err++; $display("FAIL contend_grants: got %0d want 4", log_id.size() - base); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++; if (log_id[base+k] != exp_id[k]) begin n_err++; $display("FAIL contend_id%0d: got %0d want %0d", k, log_id[base+k], exp_id[k]); end
                n_vec++; if (log_data[base+k] !== exp_dat[k]) begin n_err++; $display("FAIL contend_data%0d: got %h want %h", k, log_data[base+k], exp_dat[k]); end
            end
        end
        n_vec++; if (send_rises - s0 != 4) begin n_err++; $display("FAIL contend_frames: got %0d want 4", send_rises - s0); end
        n_vec++; if (overlap - ov0 != 0)   begin n_err++; $display("FAIL contend_overlap: got %0d want 0", overlap - ov0); end
    endtask

    task automatic test_timeout();
        int hi;
        bit ok;
        model_en = 1'b0; tb_busy = 1'b0;
        bus.req = 2'b01; bus.req_data = 16'h003C;
        wait_ack(20, ok);
        bus.req = 2'b00;
        wait_send(10, ok);
        hi = 0;
        for (int i = 0; i < 40 && bus.uart_send; i++) begin
            hi++;
            tick();
        end
        n_vec++; if (hi != 15)               begin n_err++; $display("FAIL timeout_len: got %0d want 15", hi); end
        n_vec++; if (bus.err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b want 1", bus.err_timeout); end
        wait_idle(40, ok);
        model_en = 1'b1;
        bus.req = 2'b10; bus.req_data = 16'h7E00;
        wait_ack(20, ok);
        n_vec++; if (!ok || bus.ack !== 2'b10 || bus.uart_data !== 8'h7E) begin n_err++; $display("FAIL timeout_next: ack %b data %h want 10/7e", bus.ack, bus.uart_data); end
        n_vec++; if (bus.err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b want 1", bus.err_timeout); end
        bus.req = 2'b00;
        wait_idle(80, ok);
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        n_vec++; if (bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b want 0", bus.err_timeout); end
        model_en = 1'b0;
        bus.req = 2'b01; bus.req_data = 16'h003C;
        wait_ack(20, ok);
        bus.req = 2'b00;
        wait_send(10, ok);
        repeat (14) tick();
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        n_vec++; if (bus.err_timeout !== 1'b1 || bus.uart_send !== 1'b0) begin n_err++; $display("FAIL timeout_set_vs_clear: err %b send %b want 1/0", bus.err_timeout, bus.uart_send); end
        wait_idle(40, ok);
        model_en = 1'b1;
    endtask

    task automatic test_withdraw();
        int a0, a1, s0;
        bit ok;
        a0 = ack_cnt0; a1 = ack_cnt1; s0 = send_rises;
        bus.req = 2'b10; bus.req_data = 16'h44EE;
        wait_ack(20, ok);
        n_vec++; if (!ok || bus.ack !== 2'b10) begin n_err++; $display("FAIL withdraw_ack1: got %b want 10", bus.ack); end
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        wait_idle(100, ok);
        n_vec++; if (ack_cnt0 - a0 != 0)    begin n_err++; $display("FAIL withdraw_ack0: got %0d want 0", ack_cnt0 - a0); end
        n_vec++; if (ack_cnt1 - a1 != 1)    begin n_err++; $display("FAIL withdraw_ack1_count: got %0d want 1", ack_cnt1 - a1); end
        n_vec++; if (send_rises - s0 != 1)  begin n_err++; $display("FAIL withdraw_frames: got %0d want 1", send_rises - s0); end
        n_vec++; if (bus.uart_data !== 8'h44) begin n_err++; $display("FAIL withdraw_data: got %h want 44", bus.uart_data); end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        model_en = 1'b0; tb_busy = 1'b0;
        bus.req = 2'b10; bus.req_data = 16'h5A00;
        wait_ack(20, ok);
        bus.req = 2'b00;
        wait_send(10, ok);
        tick(); tick();
        n_vec++; if (bus.uart_send !== 1'b1 || bus.grant_id !== 3'd1 || bus.uart_data !== 8'h5A) begin
            n_err++; $display("FAIL rstsend_pre: send %b grant %0d data %h want 1/1/5a", bus.uart_send, bus.grant_id, bus.uart_data); end
        reset = 1'b1;
        #2;
        n_vec++; if (bus.uart_send !== 1'b0)   begin n_err++; $display("FAIL rstsend_send: got %b want 0", bus.uart_send); end
        n_vec++; if (bus.uart_data !== 8'h00)  begin n_err++; $display("FAIL rstsend_data: got %h want 00", bus.uart_data); end
        n_vec++; if (bus.grant_id !== 3'd0)    begin n_err++; $display("FAIL rstsend_grant: got %0d want 0", bus.grant_id); end
        n_vec++; if (bus.err_timeout !== 1'b0) begin n_err++; $display("FAIL rstsend_err: got %b want 0", bus.err_timeout); end
        n_vec++; if (bus.ctrl_busy !== 1'b0 || bus.ack !== 2'b00) begin n_err++; $display("FAIL rstsend_ctrl: busy %b ack %b want 0/00", bus.ctrl_busy, bus.ack); end
        tick();
        reset = 1'b0;
        repeat (4) tick();
        model_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_at_reset();
        test_contention();
        test_timeout();
        test_withdraw();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
